// File: rtl/slot_dma_pkg.sv
// Shared constants for the slot-card DMA register core: register offsets,
// control-register bit positions and the bus-phase encoding.
package slot_dma_pkg;

    localparam logic [3:0] OFF_ADDR0 = 4'h0;
    localparam logic [3:0] OFF_ADDR1 = 4'h1;
    localparam logic [3:0] OFF_ADDR2 = 4'h2;
    localparam logic [3:0] OFF_ADDR3 = 4'h3;
    localparam logic [3:0] OFF_DATA  = 4'h4;
    localparam logic [3:0] OFF_CTRL  = 4'h5;
    localparam logic [3:0] OFF_CNTL  = 4'h6;
    localparam logic [3:0] OFF_CNTH  = 4'h7;
    localparam logic [3:0] OFF_BANK  = 4'hF;

    localparam int CTRL_INC       = 0;
    localparam int CTRL_DEC       = 1;
    localparam int CTRL_STRIDE_LO = 2;
    localparam int CTRL_STOP      = 4;
    localparam int CTRL_W         = 5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_PH2  = 3'd2,
        S_PH3  = 3'd3,
        S_PH4  = 3'd4,
        S_PH5  = 3'd5,
        S_PH6  = 3'd6,
        S_HOLD = 3'd7
    } phase_t;

    function automatic logic in_bus_window(input phase_t s);
        return (s >= S_PH4);
    endfunction

endpackage

// File: rtl/slot_dma_regs_if.sv
// Apple II slot bus as seen by the card: strobes, address, data in and the
// card's read-data return path.
interface slot_dma_regs_if;
    logic        PHI1;
    logic        nDEVSEL;
    logic        nIOSEL;
    logic        nIOSTRB;
    logic [10:0] A;
    logic        nWE;
    logic [7:0]  Din;
    logic [7:0]  Dout;
    logic        DOE;

    modport master (
        output PHI1, nDEVSEL, nIOSEL, nIOSTRB, A, nWE, Din,
        input  Dout, DOE
    );

    modport slave (
        input  PHI1, nDEVSEL, nIOSEL, nIOSTRB, A, nWE, Din,
        output Dout, DOE
    );
endinterface

// File: rtl/slot_phase_tracker.sv
// Follows the 6502 bus cycle as a 0..7 phase count restarted on each PHI1
// rise, and derives the registered data-bus and chip-select windows.
module slot_phase_tracker
    import slot_dma_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   phi1,
    input  logic   nwe,
    output phase_t s,
    output logic   dben,
    output logic   csen
);

    logic   phi1_r;
    logic   phi0seen_r;
    phase_t s_r;
    logic   dben_r;
    logic   csen_r;

    // Phase counter; a PHI1 rise only counts once a PHI0 half has been seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            phi1_r     <= 1'b0;
            phi0seen_r <= 1'b0;
            s_r        <= S_IDLE;
            dben_r     <= 1'b0;
            csen_r     <= 1'b0;
        end else begin
            phi1_r <= phi1;
            if (!phi1) begin
                phi0seen_r <= 1'b1;
            end
            if (phi1 && !phi1_r && phi0seen_r) begin
                s_r <= S_PH1;
            end else if (s_r == S_IDLE || s_r == S_HOLD) begin
                s_r <= s_r;
            end else begin
                s_r <= phase_t'(s_r + 3'd1);
            end
            dben_r <= in_bus_window(s_r);
            csen_r <= ((s_r == S_PH4) && nwe) || (s_r >= S_PH5);
        end
    end

    assign s    = s_r;
    assign dben = dben_r;
    assign csen = csen_r;

endmodule

// File: rtl/slot_dma_regs.sv
// Slot-card register file and RAM pointer engine: host-visible address,
// count, control and bank registers with auto-stepping data-port accesses.
module slot_dma_regs
    import slot_dma_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int CNT_W  = 16,
    parameter int BANK_W = 8
) (
    input  logic              C7M,
    input  logic              RES,
    slot_dma_regs_if.slave    bus,
    input  logic [7:0]        RDin,
    output logic [ADDR_W-1:0] RA,
    output logic              RAMCS,
    output logic              DBEN,
    output logic              CSEN,
    output logic              IOROMEN,
    output logic [BANK_W-1:0] Bank,
    output logic              TZ
);

    phase_t s_s;
    logic   dben_s;
    logic   csen_s;

    logic              regen_r;
    logic              ioromen_r;
    logic              pending_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [BANK_W-1:0] bank_r;

    logic [3:0]        off_s;
    logic              sel_s;
    logic              ramsel_s;
    logic              wr_s;
    logic              tz_s;
    logic [ADDR_W-1:0] stride_s;
    logic [31:0]       addr_ext_s;
    logic [31:0]       addr_wr_s;
    logic [15:0]       cnt_ext_s;
    logic [15:0]       cnt_wr_s;
    logic [7:0]        rdata_s;

    slot_phase_tracker u_phase (
        .clk  (C7M),
        .rst  (RES),
        .phi1 (bus.PHI1),
        .nwe  (bus.nWE),
        .s    (s_s),
        .dben (dben_s),
        .csen (csen_s)
    );

    assign off_s    = bus.A[3:0];
    assign sel_s    = !bus.nDEVSEL && regen_r;
    assign ramsel_s = sel_s && (off_s == OFF_DATA);
    assign wr_s     = sel_s && !bus.nWE && (s_s == S_PH6);
    assign tz_s     = (cnt_r == '0);
    assign stride_s = ADDR_W'(1'b1) << ctrl_r[CTRL_STRIDE_LO +: 2];

    // Byte-merge views of the narrow registers; bytes beyond the register width fall away on truncation.
    always_comb begin
        addr_ext_s = 32'(addr_r);
        addr_wr_s  = addr_ext_s;
        addr_wr_s[{off_s[1:0], 3'b000} +: 8] = bus.Din;
        cnt_ext_s  = 16'(cnt_r);
        cnt_wr_s   = cnt_ext_s;
        if (off_s == OFF_CNTH) begin
            cnt_wr_s[15:8] = bus.Din;
        end else begin
            cnt_wr_s[7:0] = bus.Din;
        end
    end

    // Host read-data mux.
    always_comb begin
        rdata_s = 8'h00;
        case (off_s)
            OFF_ADDR0, OFF_ADDR1,
            OFF_ADDR2, OFF_ADDR3: rdata_s = addr_ext_s[{off_s[1:0], 3'b000} +: 8];
            OFF_DATA:             rdata_s = RDin;
            OFF_CTRL:             rdata_s = {tz_s, 2'b00, ctrl_r};
            OFF_CNTL:             rdata_s = cnt_ext_s[7:0];
            OFF_CNTH:             rdata_s = cnt_ext_s[15:8];
            OFF_BANK:             rdata_s = 8'(bank_r);
            default:              rdata_s = 8'h00;
        endcase
    end

    // Register file, slot enables and pointer engine. Pointer steps at S1 and host writes at S6 never coincide.
    always_ff @(posedge C7M) begin
        if (RES) begin
            regen_r   <= 1'b0;
            ioromen_r <= 1'b0;
            pending_r <= 1'b0;
            addr_r    <= '0;
            cnt_r     <= '0;
            ctrl_r    <= '0;
            bank_r    <= '0;
        end else begin
            if (s_s == S_PH4 && !bus.nIOSEL) begin
                regen_r <= 1'b1;
            end
            if (s_s == S_PH4 && !bus.nIOSTRB && bus.A == 11'h7FF) begin
                ioromen_r <= 1'b0;
            end else if (s_s == S_PH4 && !bus.nIOSEL) begin
                ioromen_r <= 1'b1;
            end

            if (s_s == S_PH1 && pending_r) begin
                pending_r <= 1'b0;
                if (!(ctrl_r[CTRL_STOP] && tz_s)) begin
                    if (ctrl_r[CTRL_INC]) begin
                        addr_r <= addr_r + stride_s;
                    end else if (ctrl_r[CTRL_DEC]) begin
                        addr_r <= addr_r - stride_s;
                    end
                    if (!tz_s) begin
                        cnt_r <= cnt_r - CNT_W'(1'b1);
                    end
                end
            end

            if (s_s == S_PH6 && ramsel_s) begin
                pending_r <= 1'b1;
            end

            if (wr_s) begin
                case (off_s)
                    OFF_ADDR0, OFF_ADDR1,
                    OFF_ADDR2, OFF_ADDR3: addr_r <= addr_wr_s[ADDR_W-1:0];
                    OFF_CTRL:             ctrl_r <= bus.Din[CTRL_W-1:0];
                    OFF_CNTL, OFF_CNTH:   cnt_r  <= cnt_wr_s[CNT_W-1:0];
                    OFF_BANK:             bank_r <= bus.Din[BANK_W-1:0];
                    default:              ;
                endcase
            end
        end
    end

    assign bus.Dout = rdata_s;
    assign bus.DOE  = dben_s && bus.nWE && !bus.nDEVSEL && regen_r;
    assign RA       = addr_r;
    assign RAMCS    = ramsel_s && csen_s;
    assign DBEN     = dben_s;
    assign CSEN     = csen_s;
    assign IOROMEN  = ioromen_r;
    assign Bank     = bank_r;
    assign TZ       = tz_s;

endmodule
